// File: rtl/mdu.sv
// mdu: iterative RV32M/RV64M multiply/divide unit for the multi-cycle core.
//
// One operation is accepted on a start strobe. Operands are reduced to
// magnitudes, XLEN radix-2 steps run (shift-add for multiply, restoring
// shift-subtract for divide), and a final fix-up cycle restores the sign,
// selects the half/quotient/remainder and registers rd/flags. done pulses
// for one cycle; a new start is accepted in that cycle.
//
// Ports:
//   clk    in   1     clock, rising edge
//   reset  in   1     synchronous active-high reset
//   start  in   1     request, sampled only when busy = 0
//   op     in   3     funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   rs1    in   XLEN  multiplicand / dividend
//   rs2    in   XLEN  multiplier / divisor
//   busy   out  1     operation in progress (CALC or FIX)
//   done   out  1     one-cycle completion pulse
//   rd     out  XLEN  result, held until the next completion
//   flags  out  4     {rd msb, rd==0, divide-by-zero, signed overflow}
module mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rd,
  output logic [3:0]      flags
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [CW-1:0]          LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0]        MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic signed [XLEN-1:0] S_ZERO    = '0;

  function automatic logic [XLEN-1:0] cond_neg(input logic n, input logic [XLEN-1:0] v);
    return n ? ({XLEN{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic n, input logic [2*XLEN-1:0] v);
    return n ? ({(2*XLEN){1'b0}} - v) : v;
  endfunction

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_opnd;     // multiplicand magnitude, or divisor magnitude
  logic [2*XLEN-1:0] r_acc;      // {partial product, multiplier} or {remainder, quotient}
  logic              r_neg_q;    // product / quotient sign
  logic              r_neg_r;    // remainder sign (dividend sign)
  logic              r_divz;
  logic              r_ovf;
  logic [XLEN-1:0]   r_rd;
  logic [3:0]        r_flags;

  logic signed [XLEN-1:0] w_rs1_s;
  logic signed [XLEN-1:0] w_rs2_s;
  logic                   w_accept;
  logic                   w_a_signed;
  logic                   w_b_signed;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic                   w_divz;
  logic                   w_ovf;
  logic [XLEN-1:0]        w_mag_a;
  logic [XLEN-1:0]        w_mag_b;
  logic [XLEN:0]          w_mul_sum;
  logic [XLEN:0]          w_div_trial;
  logic [2*XLEN-1:0]      w_acc_next;
  logic [2*XLEN-1:0]      w_prod;
  logic [XLEN-1:0]        w_quo;
  logic [XLEN-1:0]        w_rem;
  logic [XLEN-1:0]        w_res;

  assign busy  = (r_state == S_CALC) || (r_state == S_FIX);
  assign done  = (r_state == S_DONE);
  assign rd    = r_rd;
  assign flags = r_flags;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Accept-edge decode: signedness, magnitudes, special cases
  assign w_rs1_s    = rs1;
  assign w_rs2_s    = rs2;
  assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg    = w_a_signed && (w_rs1_s < S_ZERO);
  assign w_b_neg    = w_b_signed && (w_rs2_s < S_ZERO);
  assign w_mag_a    = cond_neg(w_a_neg, rs1);
  assign w_mag_b    = cond_neg(w_b_neg, rs2);
  assign w_divz     = op[2] && (rs2 == '0);
  assign w_ovf      = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MOST_NEG) && (rs2 == '1);

  // CALC: one radix-2 step
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : {XLEN{1'b0}})};
    w_div_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opnd};
    if (r_op[2]) begin
      // Borrow out means the trial subtract failed: keep the shifted remainder.
      if (w_div_trial[XLEN]) begin
        w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
      end else begin
        w_acc_next = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  // FIX: sign restore and result select
  always_comb begin
    w_prod = cond_neg_wide(r_neg_q, r_acc);
    w_quo  = cond_neg(r_neg_q, r_acc[XLEN-1:0]);
    w_rem  = cond_neg(r_neg_r, r_acc[2*XLEN-1:XLEN]);
    case (r_op)
      3'b000:                 w_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_res = w_quo;
      default:                w_res = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_CALC;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= S_FIX;
          end
        end
        default: begin
          r_rd    <= w_res;
          r_flags <= {w_res[XLEN-1], (w_res == '0), r_divz, r_ovf};
          r_state <= S_DONE;
        end
      endcase
    end
  end

  // Datapath registers: loaded at accept, stepped in CALC
  always_ff @(posedge clk) begin
    if (w_accept && !reset) begin
      r_op    <= op;
      r_opnd  <= op[2] ? w_mag_b : w_mag_a;
      r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_mag_a : w_mag_b)};
      // With a zero divisor every trial subtract succeeds, leaving an
      // all-ones quotient magnitude and the dividend magnitude as remainder;
      // suppressing the quotient sign yields the required all-ones result.
      r_neg_q <= (w_a_neg ^ w_b_neg) && !w_divz;
      r_neg_r <= w_a_neg;
      r_divz  <= w_divz;
      r_ovf   <= w_ovf;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_next;
    end
  end

endmodule
